// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_unit
// Purpose  : WB-side sequencer for CSR accesses, exception/ERTN commit and
//            the pipeline flush that follows them.
// Revision : 1.0
// ============================================================================
module csr_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic [31:0] ws_pc,
    input  logic [2:0]  ws_op,
    input  logic [13:0] ws_csr_num,
    input  logic [31:0] ws_rj_value,
    input  logic [31:0] ws_rd_value,
    input  logic [4:0]  ws_rd,
    input  logic        ws_ex,
    input  logic [5:0]  ws_ecode,
    input  logic [8:0]  ws_esubcode,
    input  logic [31:0] ws_vaddr,
    output logic        csr_re,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    input  logic [31:0] csr_rvalue,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era,
    input  logic        has_int,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic        csr_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_EXC  = 3'd1,
        K_ERTN = 3'd2,
        K_RD   = 3'd3,
        K_WR   = 3'd4,
        K_XCHG = 3'd5
    } kind_t;

    state_t      r_state_q, w_state_d;
    kind_t       r_kind_q,  w_kind_d;
    logic [31:0] r_pc_q,    w_pc_d;
    logic [13:0] r_num_q,   w_num_d;
    logic [31:0] r_rj_q,    w_rj_d;
    logic [31:0] r_rdv_q,   w_rdv_d;
    logic [4:0]  r_rd_q,    w_rd_d;
    logic [5:0]  r_ecode_q, w_ecode_d;
    logic [8:0]  r_esub_q,  w_esub_d;
    logic [31:0] r_vaddr_q, w_vaddr_d;

    logic w_exec;
    logic w_flush_st;
    logic w_csr_op;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_q <= S_IDLE;
            r_kind_q  <= K_NONE;
            r_pc_q    <= 32'd0;
            r_num_q   <= 14'd0;
            r_rj_q    <= 32'd0;
            r_rdv_q   <= 32'd0;
            r_rd_q    <= 5'd0;
            r_ecode_q <= 6'd0;
            r_esub_q  <= 9'd0;
            r_vaddr_q <= 32'd0;
        end else begin
            r_state_q <= w_state_d;
            r_kind_q  <= w_kind_d;
            r_pc_q    <= w_pc_d;
            r_num_q   <= w_num_d;
            r_rj_q    <= w_rj_d;
            r_rdv_q   <= w_rdv_d;
            r_rd_q    <= w_rd_d;
            r_ecode_q <= w_ecode_d;
            r_esub_q  <= w_esub_d;
            r_vaddr_q <= w_vaddr_d;
        end
    end

    // Instruction class is frozen at accept so later has_int changes are ignored.
    always_comb begin
        w_state_d = r_state_q;
        w_kind_d  = r_kind_q;
        w_pc_d    = r_pc_q;
        w_num_d   = r_num_q;
        w_rj_d    = r_rj_q;
        w_rdv_d   = r_rdv_q;
        w_rd_d    = r_rd_q;
        w_ecode_d = r_ecode_q;
        w_esub_d  = r_esub_q;
        w_vaddr_d = r_vaddr_q;
        case (r_state_q)
            S_IDLE: begin
                if (ws_valid) begin
                    w_state_d = S_EXEC;
                    w_pc_d    = ws_pc;
                    w_num_d   = ws_csr_num;
                    w_rj_d    = ws_rj_value;
                    w_rdv_d   = ws_rd_value;
                    w_rd_d    = ws_rd;
                    w_vaddr_d = ws_vaddr;
                    w_ecode_d = has_int ? 6'd0 : ws_ecode;
                    w_esub_d  = has_int ? 9'd0 : ws_esubcode;
                    if (has_int || ws_ex) begin
                        w_kind_d = K_EXC;
                    end else begin
                        case (ws_op)
                            3'd1:    w_kind_d = K_RD;
                            3'd2:    w_kind_d = K_WR;
                            3'd3:    w_kind_d = K_XCHG;
                            3'd4:    w_kind_d = K_ERTN;
                            default: w_kind_d = K_NONE;
                        endcase
                    end
                end
            end
            S_EXEC:  w_state_d = (r_kind_q == K_EXC || r_kind_q == K_ERTN) ? S_FLUSH : S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Every output is qualified by resetn so an abort silences the current cycle.
    assign w_exec     = resetn && (r_state_q == S_EXEC);
    assign w_flush_st = resetn && (r_state_q == S_FLUSH);
    assign w_csr_op   = (r_kind_q == K_RD) || (r_kind_q == K_WR) || (r_kind_q == K_XCHG);
    assign ws_ready   = resetn && (r_state_q == S_IDLE);

    always_comb begin
        csr_re       = 1'b0;
        csr_we       = 1'b0;
        csr_num      = 14'd0;
        csr_wmask    = 32'd0;
        csr_wvalue   = 32'd0;
        wb_ex        = 1'b0;
        ertn_flush   = 1'b0;
        wb_pc        = 32'd0;
        wb_vaddr     = 32'd0;
        wb_ecode     = 6'd0;
        wb_esubcode  = 9'd0;
        rf_we        = 1'b0;
        rf_waddr     = 5'd0;
        rf_wdata     = 32'd0;
        flush        = 1'b0;
        flush_target = 32'd0;
        csr_busy     = 1'b0;
        if (w_exec) begin
            if (w_csr_op) begin
                csr_re   = 1'b1;
                csr_num  = r_num_q;
                rf_we    = (r_rd_q != 5'd0);
                rf_waddr = r_rd_q;
                rf_wdata = csr_rvalue;
            end
            case (r_kind_q)
                K_EXC: begin
                    wb_ex       = 1'b1;
                    wb_pc       = r_pc_q;
                    wb_vaddr    = r_vaddr_q;
                    wb_ecode    = r_ecode_q;
                    wb_esubcode = r_esub_q;
                    csr_busy    = 1'b1;
                end
                K_ERTN: begin
                    ertn_flush = 1'b1;
                    csr_busy   = 1'b1;
                end
                K_WR: begin
                    csr_we     = 1'b1;
                    csr_wmask  = 32'hFFFF_FFFF;
                    csr_wvalue = r_rdv_q;
                    csr_busy   = 1'b1;
                end
                K_XCHG: begin
                    csr_we     = 1'b1;
                    csr_wmask  = r_rj_q;
                    csr_wvalue = r_rdv_q;
                    csr_busy   = 1'b1;
                end
                default: ;
            endcase
        end
        if (w_flush_st) begin
            flush        = 1'b1;
            flush_target = (r_kind_q == K_EXC) ? ex_entry : era;
            csr_busy     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_access_unit
// Purpose  : Directed vector bench for csr_access_unit with a small CSR model.
// Revision : 1.0
// ============================================================================
module tb_csr_access_unit;

    localparam logic [31:0] C_EX_ENTRY = 32'h1C00_8000;
    localparam logic [31:0] C_ERA      = 32'h1C00_0100;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid;
    logic        ws_ready;
    logic [31:0] ws_pc;
    logic [2:0]  ws_op;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_rj_value;
    logic [31:0] ws_rd_value;
    logic [4:0]  ws_rd;
    logic        ws_ex;
    logic [5:0]  ws_ecode;
    logic [8:0]  ws_esubcode;
    logic [31:0] ws_vaddr;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue;
    logic        wb_ex, ertn_flush;
    logic [31:0] wb_pc, wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] ex_entry, era;
    logic        has_int;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_target;
    logic        csr_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_access_unit dut (
        .clk(clk), .resetn(resetn), .ws_valid(ws_valid), .ws_ready(ws_ready),
        .ws_pc(ws_pc), .ws_op(ws_op), .ws_csr_num(ws_csr_num),
        .ws_rj_value(ws_rj_value), .ws_rd_value(ws_rd_value), .ws_rd(ws_rd),
        .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
        .ws_vaddr(ws_vaddr), .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .ex_entry(ex_entry),
        .era(era), .has_int(has_int), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flush(flush), .flush_target(flush_target),
        .csr_busy(csr_busy)
    );

    // Minimal CSR file: SAVE0 (0x30) and PRMD (0x1), everything else reads 0.
    logic [31:0] save0, prmd;
    assign csr_rvalue = (csr_num == 14'h30) ? save0 : (csr_num == 14'h1) ? prmd : 32'd0;
    always @(posedge clk) begin
        if (!resetn) begin
            save0 <= 32'hA;
            prmd  <= 32'h0;
        end else if (csr_we) begin
            if (csr_num == 14'h30) save0 <= (save0 & ~csr_wmask) | (csr_wvalue & csr_wmask);
            if (csr_num == 14'h1)  prmd  <= (prmd  & ~csr_wmask) | (csr_wvalue & csr_wmask);
        end
    end

    typedef struct {
        logic [2:0]  op;   logic [13:0] num;  logic [31:0] rj;   logic [31:0] rdv;
        logic [4:0]  rd;   logic        ex;   logic [5:0]  ecode; logic [8:0] esub;
        logic [31:0] vaddr; logic       hint; logic [31:0] pc;
        logic        e_re; logic        e_we; logic [31:0] e_mask; logic [31:0] e_wval;
        logic        e_rfwe; logic [4:0] e_waddr; logic [31:0] e_wdata;
        logic        e_wbex; logic [5:0] e_ecode; logic [8:0] e_esub;
        logic [31:0] e_vaddr; logic [31:0] e_wbpc;
        logic        e_ertn; logic      e_busy; logic e_flush; logic [31:0] e_target;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ws_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", 32'(ws_ready), 32'd1);
    endtask

    task automatic drive(input logic [2:0] op, input logic [13:0] num, input logic [31:0] rj,
                         input logic [31:0] rdv, input logic [4:0] rd, input logic ex,
                         input logic [5:0] ecode, input logic [8:0] esub,
                         input logic [31:0] vaddr, input logic hint, input logic [31:0] pc);
        ws_valid = 1'b1; ws_op = op; ws_csr_num = num; ws_rj_value = rj; ws_rd_value = rdv;
        ws_rd = rd; ws_ex = ex; ws_ecode = ecode; ws_esubcode = esub; ws_vaddr = vaddr;
        has_int = hint; ws_pc = pc;
    endtask

    task automatic run_vec(input int idx);
        vec_t v = vecs[idx];
        wait_ready();
        drive(v.op, v.num, v.rj, v.rdv, v.rd, v.ex, v.ecode, v.esub, v.vaddr, v.hint, v.pc);
        @(negedge clk);
        ws_valid = 1'b0;
        has_int  = 1'b0;
        chk($sformatf("v%0d ws_ready_exec", idx), 32'(ws_ready), 32'd0);
        chk($sformatf("v%0d csr_re", idx), 32'(csr_re), 32'(v.e_re));
        chk($sformatf("v%0d csr_we", idx), 32'(csr_we), 32'(v.e_we));
        chk($sformatf("v%0d csr_wmask", idx), csr_wmask, v.e_mask);
        chk($sformatf("v%0d csr_wvalue", idx), csr_wvalue, v.e_wval);
        chk($sformatf("v%0d rf_we", idx), 32'(rf_we), 32'(v.e_rfwe));
        chk($sformatf("v%0d rf_waddr", idx), 32'(rf_waddr), 32'(v.e_waddr));
        chk($sformatf("v%0d rf_wdata", idx), rf_wdata, v.e_wdata);
        chk($sformatf("v%0d wb_ex", idx), 32'(wb_ex), 32'(v.e_wbex));
        chk($sformatf("v%0d wb_ecode", idx), 32'(wb_ecode), 32'(v.e_ecode));
        chk($sformatf("v%0d wb_esubcode", idx), 32'(wb_esubcode), 32'(v.e_esub));
        chk($sformatf("v%0d wb_vaddr", idx), wb_vaddr, v.e_vaddr);
        chk($sformatf("v%0d wb_pc", idx), wb_pc, v.e_wbpc);
        chk($sformatf("v%0d ertn_flush", idx), 32'(ertn_flush), 32'(v.e_ertn));
        chk($sformatf("v%0d csr_busy_exec", idx), 32'(csr_busy), 32'(v.e_busy));
        chk($sformatf("v%0d flush_exec", idx), 32'(flush), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d flush_next", idx), 32'(flush), 32'(v.e_flush));
        chk($sformatf("v%0d busy_next", idx), 32'(csr_busy), 32'(v.e_flush));
        chk($sformatf("v%0d ready_next", idx), 32'(ws_ready), 32'(!v.e_flush));
        chk($sformatf("v%0d wb_ex_next", idx), 32'(wb_ex), 32'd0);
        if (v.e_flush) begin
            chk($sformatf("v%0d flush_target", idx), flush_target, v.e_target);
            @(negedge clk);
            chk($sformatf("v%0d ready_after_flush", idx), 32'(ws_ready), 32'd1);
            chk($sformatf("v%0d flush_cleared", idx), 32'(flush), 32'd0);
        end
    endtask

    initial begin
        // op num rj rdv rd ex ecode esub vaddr hint pc | re we mask wval rfwe waddr wdata wbex ecode esub vaddr wbpc ertn busy flush target
        vecs[0]  = '{3'd2, 14'h30, 32'h0, 32'h12345678, 5'd5, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000000,
                     1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 5'd5, 32'hA, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{3'd1, 14'h30, 32'h0, 32'h0, 5'd3, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000004,
                     1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h12345678, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{3'd3, 14'h1, 32'h4, 32'h7, 5'd0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000008,
                     1'b1, 1'b1, 32'h4, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{3'd1, 14'h1, 32'h0, 32'h0, 5'd2, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C00000C,
                     1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd2, 32'h4, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{3'd2, 14'h30, 32'h0, 32'hFFFF0000, 5'd5, 1'b1, 6'h09, 9'h1, 32'h1003, 1'b0, 32'h1C000010,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 6'h09, 9'h1, 32'h1003, 32'h1C000010, 1'b0, 1'b1, 1'b1, C_EX_ENTRY};
        vecs[5]  = '{3'd1, 14'h30, 32'h0, 32'h0, 5'd4, 1'b0, 6'h0, 9'h0, 32'h0, 1'b1, 32'h1C000014,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 6'h0, 9'h0, 32'h0, 32'h1C000014, 1'b0, 1'b1, 1'b1, C_EX_ENTRY};
        vecs[6]  = '{3'd3, 14'h1, 32'hF, 32'hF, 5'd7, 1'b1, 6'h03, 9'h2, 32'h0, 1'b1, 32'h1C000018,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 6'h0, 9'h0, 32'h0, 32'h1C000018, 1'b0, 1'b1, 1'b1, C_EX_ENTRY};
        vecs[7]  = '{3'd4, 14'h0, 32'h0, 32'h0, 5'd0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C00001C,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, C_ERA};
        vecs[8]  = '{3'd5, 14'h30, 32'h1, 32'h1, 5'd1, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000020,
                     1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{3'd2, 14'h30, 32'h0, 32'hDEADBEEF, 5'd0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000024,
                     1'b1, 1'b1, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b0, 5'd0, 32'h12345678, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{3'd1, 14'h30, 32'h0, 32'h0, 5'd31, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000028,
                     1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 6'h0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};

        ex_entry = C_EX_ENTRY;
        era      = C_ERA;
        resetn   = 1'b0;
        drive(3'd0, 14'h0, 32'h0, 32'h0, 5'd0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h0);
        ws_valid = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Idle after reset: ready, nothing firing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_ready", 32'(ws_ready), 32'd1);
            chk("reset_quiet", {26'd0, csr_re, csr_we, wb_ex, ertn_flush, flush, rf_we}, 32'd0);
            chk("reset_busy", 32'(csr_busy), 32'd0);
        end

        for (int i = 0; i < 11; i++) run_vec(i);

        // has_int rising after accept must not turn a held CSRRD into an exception.
        wait_ready();
        drive(3'd1, 14'h30, 32'h0, 32'h0, 5'd6, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000030);
        @(negedge clk);
        ws_valid = 1'b0;
        has_int  = 1'b1;
        #1;
        chk("late_int_wb_ex", 32'(wb_ex), 32'd0);
        chk("late_int_rf_we", 32'(rf_we), 32'd1);
        chk("late_int_rf_wdata", rf_wdata, 32'hDEADBEEF);
        @(negedge clk);
        has_int = 1'b0;
        chk("late_int_no_flush", 32'(flush), 32'd0);

        // ERTN aborted by reset while in EXEC: no pulse now or later.
        wait_ready();
        drive(3'd4, 14'h0, 32'h0, 32'h0, 5'd0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, 32'h1C000034);
        @(negedge clk);
        ws_valid = 1'b0;
        chk("abort_pre_ertn", 32'(ertn_flush), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_ertn", 32'(ertn_flush), 32'd0);
        chk("abort_busy", 32'(csr_busy), 32'd0);
        @(negedge clk);
        chk("abort_flush_in_reset", 32'(flush), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("abort_flush_after", 32'(flush), 32'd0);
        chk("abort_ready_after", 32'(ws_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
